// File: rtl/sink_byte_serializer_pkg.sv
// Shared constants and types for the snk-word to byte-stream serializer.
package serializer_config;

    localparam int BYTE_WIDTH = 8;

    typedef enum logic {
        SER_IDLE,
        SER_SEND
    } ser_state_t;

    // Number of whole bytes needed to carry a w-bit word (rounded up).
    function automatic int num_bytes(input int w);
        return (w + BYTE_WIDTH - 1) / BYTE_WIDTH;
    endfunction

endpackage

// File: rtl/sink_byte_serializer.sv
// Splits each SNK_WIDTH-bit sink word into bytes, MSB first, with a
// zero-bubble handoff between words when the last byte is taken.
module sink_byte_serializer
    import serializer_config::*;
#(
    parameter int SNK_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 snk_valid,
    output logic                 snk_ready,
    input  logic [SNK_WIDTH-1:0] snk,
    output logic                 byte_valid,
    input  logic                 byte_ready,
    output logic [7:0]           byte_data
);

    localparam int NUM_BYTES = num_bytes(SNK_WIDTH);
    localparam int SHIFT_W   = NUM_BYTES * BYTE_WIDTH;
    localparam int CNT_W     = $clog2(NUM_BYTES) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    ser_state_t         state_q, state_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SHIFT_W-1:0] snk_ext;
    logic               last_byte;
    logic               load;

    always_comb begin
        snk_ext                = '0;
        snk_ext[SNK_WIDTH-1:0] = snk;
    end

    assign last_byte = (state_q == SER_SEND) && (cnt_q == '0);
    // byte_ready -> snk_ready is the only combinational path through the block.
    assign snk_ready = (state_q == SER_IDLE) || (last_byte && byte_ready);
    assign load      = snk_valid && snk_ready;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            SER_IDLE: begin
                if (load) begin
                    shift_d = snk_ext;
                    cnt_d   = LAST_IDX;
                    state_d = SER_SEND;
                end
            end
            SER_SEND: begin
                if (byte_ready) begin
                    if (cnt_q != '0) begin
                        shift_d = shift_q << BYTE_WIDTH;
                        cnt_d   = cnt_q - CNT_W'(1);
                    end else if (snk_valid) begin
                        shift_d = snk_ext;
                        cnt_d   = LAST_IDX;
                    end else begin
                        // Flush so byte_data reads zero while idle.
                        shift_d = shift_q << BYTE_WIDTH;
                        state_d = SER_IDLE;
                    end
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SER_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign byte_valid = (state_q == SER_SEND);
    assign byte_data  = shift_q[SHIFT_W-1 -: BYTE_WIDTH];

endmodule

// File: tb/tb_sink_byte_serializer.sv
// Directed bench for sink_byte_serializer at word widths 12, 8 and 16.
module tb_sink_byte_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        v12 = 1'b0, r12 = 1'b0, rdy12, bv12;
    logic [11:0] s12 = '0;
    logic [7:0]  bd12;
    logic        v8 = 1'b0, r8 = 1'b0, rdy8, bv8;
    logic [7:0]  s8 = '0;
    logic [7:0]  bd8;
    logic        v16 = 1'b0, r16 = 1'b0, rdy16, bv16;
    logic [15:0] s16 = '0;
    logic [7:0]  bd16;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sink_byte_serializer #(.SNK_WIDTH(12)) u12 (
        .clk(clk), .rst(rst), .snk_valid(v12), .snk_ready(rdy12), .snk(s12),
        .byte_valid(bv12), .byte_ready(r12), .byte_data(bd12));
    sink_byte_serializer #(.SNK_WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .snk_valid(v8), .snk_ready(rdy8), .snk(s8),
        .byte_valid(bv8), .byte_ready(r8), .byte_data(bd8));
    sink_byte_serializer #(.SNK_WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .snk_valid(v16), .snk_ready(rdy16), .snk(s16),
        .byte_valid(bv16), .byte_ready(r16), .byte_data(bd16));

    typedef struct {
        logic        sv;
        logic [15:0] d;
        logic        br;
        logic        er;
        logic        ev;
        logic [7:0]  ed;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive on the falling edge, sample 1ns later, before the rising edge.
    task automatic cyc(input int sel, input logic sv, input logic [15:0] d, input logic br,
                       input logic er, input logic ev, input logic [7:0] ed, input string tag);
        logic       a_r, a_v;
        logic [7:0] a_d;
        @(negedge clk);
        case (sel)
            8:       begin v8  = sv; s8  = d[7:0];  r8  = br; end
            16:      begin v16 = sv; s16 = d;       r16 = br; end
            default: begin v12 = sv; s12 = d[11:0]; r12 = br; end
        endcase
        #1;
        case (sel)
            8:       begin a_r = rdy8;  a_v = bv8;  a_d = bd8;  end
            16:      begin a_r = rdy16; a_v = bv16; a_d = bd16; end
            default: begin a_r = rdy12; a_v = bv12; a_d = bd12; end
        endcase
        $display("w%0d %s: snk_valid=%b snk=%h byte_ready=%b -> snk_ready=%b byte_valid=%b byte_data=%h",
                 sel, tag, sv, d, br, a_r, a_v, a_d);
        check({tag, ".snk_ready"}, {15'd0, a_r}, {15'd0, er});
        check({tag, ".byte_valid"}, {15'd0, a_v}, {15'd0, ev});
        check({tag, ".byte_data"}, {8'd0, a_d}, {8'd0, ed});
    endtask

    initial begin
        // SNK_WIDTH=12: single word, back-to-back words, backpressure.
        tbl[0]  = '{1'b1, 16'h0ABC, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h0A};
        tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'hBC};
        tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[4]  = '{1'b1, 16'h0123, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[5]  = '{1'b1, 16'h0456, 1'b1, 1'b0, 1'b1, 8'h01};
        tbl[6]  = '{1'b1, 16'h0456, 1'b1, 1'b1, 1'b1, 8'h23};
        tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h04};
        tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h56};
        tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[10] = '{1'b1, 16'h0FFF, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h0F};
        tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h0F};
        tbl[13] = '{1'b1, 16'h0AAA, 1'b0, 1'b0, 1'b1, 8'hFF};
        tbl[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'hFF};
        tbl[15] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'hFF};
        tbl[16] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst.w12.snk_ready",  {15'd0, rdy12}, 16'd1);
        check("rst.w12.byte_valid", {15'd0, bv12},  16'd0);
        check("rst.w12.byte_data",  {8'd0, bd12},   16'd0);
        check("rst.w8.byte_valid",  {15'd0, bv8},   16'd0);
        check("rst.w16.byte_valid", {15'd0, bv16},  16'd0);

        for (int i = 0; i < 17; i++) begin
            cyc(12, tbl[i].sv, tbl[i].d, tbl[i].br, tbl[i].er, tbl[i].ev, tbl[i].ed,
                $sformatf("tbl%0d", i));
        end

        // SNK_WIDTH=8: one byte per word, snk_ready held high while draining.
        cyc(8, 1'b1, 16'h005A, 1'b1, 1'b1, 1'b0, 8'h00, "w8_load5A");
        cyc(8, 1'b1, 16'h00A5, 1'b1, 1'b1, 1'b1, 8'h5A, "w8_5A");
        cyc(8, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'hA5, "w8_A5");
        cyc(8, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00, "w8_idle");

        // SNK_WIDTH=16: stalled output with snk_valid held; only one word taken.
        cyc(16, 1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0, 8'h00, "w16_load");
        for (int i = 0; i < 5; i++) begin
            cyc(16, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1, 8'hBE, $sformatf("w16_stall%0d", i));
        end
        cyc(16, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'hBE, "w16_BE");
        cyc(16, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'hEF, "w16_EF");
        cyc(16, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00, "w16_idle");

        // SNK_WIDTH=12: reset after the first byte drops the rest of the word.
        cyc(12, 1'b1, 16'h0ABC, 1'b1, 1'b1, 1'b0, 8'h00, "rst_load");
        cyc(12, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h0A, "rst_b0");
        @(negedge clk);
        rst = 1'b1;
        r12 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst.snk_ready",  {15'd0, rdy12}, 16'd1);
        check("midrst.byte_valid", {15'd0, bv12},  16'd0);
        check("midrst.byte_data",  {8'd0, bd12},   16'd0);
        cyc(12, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 8'h00, "rst_load001");
        cyc(12, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h00, "rst_b00");
        cyc(12, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h01, "rst_b01");
        cyc(12, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00, "rst_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
